// File: rtl/nf10_output_demux.sv
// One-to-five AXI-Stream demultiplexer: a single shared beat register is presented to
// every output selected by the packet's destination mask (multicast), with per-port counters.
module nf10_output_demux #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_DST_PORT_POS       = 24
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_0,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
  output logic                              m_axis_tvalid_0,
  output logic                              m_axis_tlast_0,
  input  logic                              m_axis_tready_0,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_1,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
  output logic                              m_axis_tvalid_1,
  output logic                              m_axis_tlast_1,
  input  logic                              m_axis_tready_1,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_2,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_2,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_2,
  output logic                              m_axis_tvalid_2,
  output logic                              m_axis_tlast_2,
  input  logic                              m_axis_tready_2,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_3,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_3,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_3,
  output logic                              m_axis_tvalid_3,
  output logic                              m_axis_tlast_3,
  input  logic                              m_axis_tready_3,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_4,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_4,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_4,
  output logic                              m_axis_tvalid_4,
  output logic                              m_axis_tlast_4,
  input  logic                              m_axis_tready_4,

  output logic [31:0]                       pkt_count_0,
  output logic [31:0]                       pkt_count_1,
  output logic [31:0]                       pkt_count_2,
  output logic [31:0]                       pkt_count_3,
  output logic [31:0]                       pkt_count_4,
  output logic [31:0]                       drop_count
);

  localparam int NP = 5;

  typedef enum logic {HEAD = 1'b0, BODY = 1'b1} state_t;

  state_t                            state_reg, state_next;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    data_reg;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  strb_reg;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   user_reg;
  logic                              last_reg;
  logic [NP-1:0]                     pend_reg, pend_next;
  logic [NP-1:0]                     cur_mask_reg, cur_mask_next;
  logic [NP-1:0][31:0]               pkt_cnt_reg, pkt_cnt_next;
  logic [31:0]                       drop_cnt_reg, drop_cnt_next;

  logic [NP-1:0] m_ready;
  logic [NP-1:0] active_mask;
  logic          accept;
  logic          head_accept;

  assign m_ready = {m_axis_tready_4, m_axis_tready_3, m_axis_tready_2,
                    m_axis_tready_1, m_axis_tready_0};

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_reg    <= HEAD;
      pend_reg     <= '0;
      cur_mask_reg <= '0;
      data_reg     <= '0;
      strb_reg     <= '0;
      user_reg     <= '0;
      last_reg     <= 1'b0;
      pkt_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pend_reg     <= pend_next;
      cur_mask_reg <= cur_mask_next;
      pkt_cnt_reg  <= pkt_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
      if (accept) begin
        data_reg <= s_axis_tdata;
        strb_reg <= s_axis_tstrb;
        user_reg <= s_axis_tuser;
        last_reg <= s_axis_tlast;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = s_axis_tlast ? HEAD : BODY;
    end
  end

  // The register may be refilled in the very cycle its last outstanding consumer takes it.
  always_comb begin
    s_axis_tready = ~|(pend_reg & ~m_ready);
    accept        = s_axis_tvalid & s_axis_tready;
    head_accept   = accept & (state_reg == HEAD);
    active_mask   = (state_reg == HEAD) ? s_axis_tuser[C_DST_PORT_POS +: NP] : cur_mask_reg;
    pend_next     = pend_reg & ~m_ready;
    cur_mask_next = cur_mask_reg;
    if (accept) begin
      pend_next = active_mask;
    end
    if (head_accept) begin
      cur_mask_next = active_mask;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_cnt
      assign pkt_cnt_next[gi] = pkt_cnt_reg[gi] + {31'd0, head_accept & active_mask[gi]};
    end
  endgenerate

  assign drop_cnt_next = drop_cnt_reg + {31'd0, head_accept & ~|active_mask};

  assign m_axis_tdata_0 = data_reg;
  assign m_axis_tdata_1 = data_reg;
  assign m_axis_tdata_2 = data_reg;
  assign m_axis_tdata_3 = data_reg;
  assign m_axis_tdata_4 = data_reg;

  assign m_axis_tstrb_0 = strb_reg;
  assign m_axis_tstrb_1 = strb_reg;
  assign m_axis_tstrb_2 = strb_reg;
  assign m_axis_tstrb_3 = strb_reg;
  assign m_axis_tstrb_4 = strb_reg;

  assign m_axis_tuser_0 = user_reg;
  assign m_axis_tuser_1 = user_reg;
  assign m_axis_tuser_2 = user_reg;
  assign m_axis_tuser_3 = user_reg;
  assign m_axis_tuser_4 = user_reg;

  assign m_axis_tlast_0 = last_reg;
  assign m_axis_tlast_1 = last_reg;
  assign m_axis_tlast_2 = last_reg;
  assign m_axis_tlast_3 = last_reg;
  assign m_axis_tlast_4 = last_reg;

  assign m_axis_tvalid_0 = pend_reg[0];
  assign m_axis_tvalid_1 = pend_reg[1];
  assign m_axis_tvalid_2 = pend_reg[2];
  assign m_axis_tvalid_3 = pend_reg[3];
  assign m_axis_tvalid_4 = pend_reg[4];

  assign pkt_count_0 = pkt_cnt_reg[0];
  assign pkt_count_1 = pkt_cnt_reg[1];
  assign pkt_count_2 = pkt_cnt_reg[2];
  assign pkt_count_3 = pkt_cnt_reg[3];
  assign pkt_count_4 = pkt_cnt_reg[4];
  assign drop_count  = drop_cnt_reg;

endmodule
